// File: rtl/acc_drain.sv
// -----------------------------------------------------------------------------
// acc_drain
//
// Output drain for the systolic array. Takes one column of R signed
// accumulator results (WY bits each) in a single parallel handshake. Each
// result is arithmetic-shifted right by SHIFT and narrowed to WO bits. The
// results then leave one per beat on an AXI-Stream master, with TLAST on the
// last beat of the column. A one-deep pending buffer lets the next column be
// accepted while the current one drains.
//
// Build option:
//   ACC_DRAIN_SAT_EN  defined   : a narrowed word saturates to the signed WO range
//                     undefined : a narrowed word keeps its low WO bits (wrap),
//                                 and no saturation comparators are built
//
// Parameters:
//   R      results per column (beats per packet), R >= 2
//   WY     accumulator result width, signed
//   WO     output word width, signed, 2 <= WO <= WY
//   SHIFT  arithmetic right shift applied before narrowing, 0 <= SHIFT < WY
//
// Ports:
//   clk            clock
//   rstn           synchronous active-low reset
//   s_valid        column valid
//   s_ready        column accepted when s_valid && s_ready (depends only on
//                  reset and pending-buffer occupancy)
//   s_data         column; result i at [i*WY +: WY]
//   m_axis_tvalid  output beat valid
//   m_axis_tready  downstream ready
//   m_axis_tdata   narrowed result
//   m_axis_tlast   high on beat R-1 of each column
//   busy           active or pending buffer occupied, or a beat is on the bus
// -----------------------------------------------------------------------------
module acc_drain #(
    parameter int R     = 8,
    parameter int WY    = 16,
    parameter int WO    = 8,
    parameter int SHIFT = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [R*WY-1:0]   s_data,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [WO-1:0]     m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              busy
);

    localparam int             IW       = $clog2(R);
    localparam logic [IW-1:0]  LAST_IDX = IW'(R - 1);

    typedef enum logic {
        IDLE,   // active buffer empty
        DRAIN   // active buffer holds a column being emitted
    } state_t;

    // Source of the next active-buffer contents.
    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_FROM_IN,
        ACT_FROM_PEND
    } act_sel_t;

    // -------------------------------------------------------------------------
    // Narrowing: sign-preserving floor shift, then saturate or wrap to WO bits.
    // -------------------------------------------------------------------------
`ifdef ACC_DRAIN_SAT_EN
    // Signed WO range limits expressed at WY width for the comparison.
    localparam logic signed [WY-1:0] SAT_MAX = {{(WY-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [WY-1:0] SAT_MIN = {{(WY-WO+1){1'b1}}, {(WO-1){1'b0}}};
`endif

    function automatic logic [WO-1:0] narrow(input logic [WY-1:0] v);
        logic signed [WY-1:0] t;
        t = $signed(v) >>> SHIFT;
`ifdef ACC_DRAIN_SAT_EN
        if (t > SAT_MAX) begin
            return SAT_MAX[WO-1:0];
        end else if (t < SAT_MIN) begin
            return SAT_MIN[WO-1:0];
        end else begin
            return t[WO-1:0];
        end
`else
        return t[WO-1:0];
`endif
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               pend_full_q, pend_full_d;
    logic [R*WY-1:0]    act_q;
    logic [R*WY-1:0]    pend_q;

    // Control decided combinationally each cycle.
    act_sel_t           act_sel;
    logic               pend_load;
    logic               out_load;
    logic               out_clear;
    logic               accept;
    logic [WY-1:0]      cur_word;

    assign s_ready  = rstn && !pend_full_q;
    assign accept   = s_valid && s_ready;
    assign cur_word = act_q[idx_q*WY +: WY];
    assign busy     = (state_q == DRAIN) || pend_full_q || m_axis_tvalid;

    // -------------------------------------------------------------------------
    // Next-state and control
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        pend_full_d = pend_full_q;
        act_sel     = ACT_HOLD;
        pend_load   = 1'b0;
        out_load    = 1'b0;
        out_clear   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The pending buffer is always empty here: a retire with a
                // pending column stays in DRAIN.
                if (accept) begin
                    act_sel = ACT_FROM_IN;
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                // The output register refills whenever it is empty or its
                // current beat is consumed this cycle.
                out_load = !m_axis_tvalid || m_axis_tready;

                if (out_load && (idx_q == LAST_IDX)) begin
                    // Last word of the column leaves the active buffer.
                    idx_d = '0;
                    if (pend_full_q) begin
                        // s_ready is low this cycle, so nothing can be accepted.
                        act_sel     = ACT_FROM_PEND;
                        pend_full_d = 1'b0;
                    end else if (accept) begin
                        act_sel = ACT_FROM_IN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (out_load) begin
                        idx_d = idx_q + 1'b1;
                    end
                    // accept implies the pending buffer is empty.
                    if (accept) begin
                        pend_load   = 1'b1;
                        pend_full_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A consumed beat with nothing to replace it drops tvalid.
        out_clear = m_axis_tvalid && m_axis_tready && !out_load;
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples values from before the edge, regardless of block order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_full_q <= pend_full_d;
        end
    end

    // -------------------------------------------------------------------------
    // Column buffers
    // -------------------------------------------------------------------------
    // NOTE: the buffer storage has no reset; the state and pend_full flag that
    // qualify it are reset, so stale contents are never emitted.
    always_ff @(posedge clk) begin
        unique case (act_sel)
            ACT_FROM_IN:   act_q <= s_data;
            ACT_FROM_PEND: act_q <= pend_q;
            default:       act_q <= act_q;
        endcase
        if (pend_load) begin
            pend_q <= s_data;
        end
    end

    // -------------------------------------------------------------------------
    // Output register. Holds tvalid/tdata/tlast stable while stalled; a load
    // only happens when the register is empty or being consumed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (out_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= narrow(cur_word);
            m_axis_tlast  <= (idx_q == LAST_IDX);
        end else if (out_clear) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_drain.sv
// -----------------------------------------------------------------------------
// tb_acc_drain
//
// Self-checking bench for acc_drain with R=4, WY=16, WO=8. Two instances share
// all inputs: one with SHIFT=0 and one with SHIFT=2, so each directed column
// checks both narrowing paths. Expected words are hand-computed per column and
// follow ACC_DRAIN_SAT_EN (saturate) or its absence (wrap).
// -----------------------------------------------------------------------------
module tb_acc_drain;

    localparam int R  = 4;
    localparam int WY = 16;
    localparam int WO = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic            s_valid;
    logic [R*WY-1:0] s_data;
    logic            m_axis_tready;

    logic            s_ready0, s_ready2;
    logic            tvalid0, tvalid2;
    logic            tlast0, tlast2;
    logic            busy0, busy2;
    logic [WO-1:0]   tdata0, tdata2;

    always #5 clk = ~clk;

    acc_drain #(.R(R), .WY(WY), .WO(WO), .SHIFT(0)) u_dut0 (
        .clk           (clk),
        .rstn          (rstn),
        .s_valid       (s_valid),
        .s_ready       (s_ready0),
        .s_data        (s_data),
        .m_axis_tvalid (tvalid0),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (tdata0),
        .m_axis_tlast  (tlast0),
        .busy          (busy0)
    );

    acc_drain #(.R(R), .WY(WY), .WO(WO), .SHIFT(2)) u_dut2 (
        .clk           (clk),
        .rstn          (rstn),
        .s_valid       (s_valid),
        .s_ready       (s_ready2),
        .s_data        (s_data),
        .m_axis_tvalid (tvalid2),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (tdata2),
        .m_axis_tlast  (tlast2),
        .busy          (busy2)
    );

    // Column vector: input column plus expected beats, beat b at [b*8 +: 8].
    typedef struct {
        logic [R*WY-1:0] col;
        logic [31:0]     e0;   // SHIFT=0 instance
        logic [31:0]     e2;   // SHIFT=2 instance
    } vec_t;

    vec_t tbl[4];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   offer_q[$];
    int   exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer column k until accepted, bounded.
    task automatic send(input int k);
        s_valid = 1'b1;
        s_data  = tbl[k].col;
        for (int i = 0; i < 20; i++) begin
            if (s_ready0) begin
                step();
                s_valid = 1'b0;
                return;
            end
            step();
        end
        s_valid = 1'b0;
        check("send timeout", 32'd0, 32'd1);
    endtask

    // Offer columns from offer_q (s_valid held while any remain), collect
    // beats, and compare them against the columns listed in exp_q.
    task automatic run_stream(input string tag, input int max_cyc);
        int   nb;
        int   ntot;
        int   first_c;
        int   last_c;
        logic busy_at_last;
        nb           = 0;
        ntot         = exp_q.size() * R;
        first_c      = -1;
        last_c       = -1;
        busy_at_last = 1'b0;
        for (int c = 0; c < max_cyc && (nb < ntot || offer_q.size() != 0); c++) begin
            logic acc;
            if (offer_q.size() != 0) begin
                s_valid = 1'b1;
                s_data  = tbl[offer_q[0]].col;
            end else begin
                s_valid = 1'b0;
            end
            acc = s_valid && s_ready0;
            check($sformatf("%s cyc%0d tvalid match", tag, c), 32'(tvalid2), 32'(tvalid0));
            if (tvalid0 && m_axis_tready) begin
                if (nb < ntot) begin
                    int col;
                    int b;
                    col = exp_q[nb / R];
                    b   = nb % R;
                    check($sformatf("%s beat%0d tdata s0", tag, nb), 32'(tdata0), 32'(tbl[col].e0[b*8 +: 8]));
                    check($sformatf("%s beat%0d tdata s2", tag, nb), 32'(tdata2), 32'(tbl[col].e2[b*8 +: 8]));
                    check($sformatf("%s beat%0d tlast", tag, nb), 32'(tlast0), 32'(b == R - 1));
                end else begin
                    check($sformatf("%s extra beat", tag), 32'd1, 32'd0);
                end
                if (first_c < 0) first_c = c;
                last_c       = c;
                busy_at_last = busy0;
                nb++;
            end
            step();
            if (acc) void'(offer_q.pop_front());
        end
        s_valid = 1'b0;
        check($sformatf("%s beat count", tag), 32'(nb), 32'(ntot));
        check($sformatf("%s gapless span", tag), 32'(last_c - first_c + 1), 32'(ntot));
        check($sformatf("%s busy on last beat", tag), 32'(busy_at_last), 32'd1);
        check($sformatf("%s busy after drain", tag), 32'(busy0), 32'd0);
        check($sformatf("%s tvalid after drain", tag), 32'(tvalid0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- vector table ----------------
        tbl[0].col = {16'h8000, 16'h0200, 16'hFFFE, 16'h0005};
        tbl[1].col = {16'hFE00, 16'h01FC, 16'hFFFE, 16'h0005};
        tbl[2].col = {16'hFF7F, 16'hFF80, 16'h0080, 16'h007F};
        tbl[3].col = {16'hEDCB, 16'h1234, 16'hFFFF, 16'h0000};
`ifdef ACC_DRAIN_SAT_EN
        tbl[0].e0 = {8'h80, 8'h7F, 8'hFE, 8'h05};
        tbl[0].e2 = {8'h80, 8'h7F, 8'hFF, 8'h01};
        tbl[1].e0 = {8'h80, 8'h7F, 8'hFE, 8'h05};
        tbl[1].e2 = {8'h80, 8'h7F, 8'hFF, 8'h01};
        tbl[2].e0 = {8'h80, 8'h80, 8'h7F, 8'h7F};
        tbl[2].e2 = {8'hDF, 8'hE0, 8'h20, 8'h1F};
        tbl[3].e0 = {8'h80, 8'h7F, 8'hFF, 8'h00};
        tbl[3].e2 = {8'h80, 8'h7F, 8'hFF, 8'h00};
`else
        tbl[0].e0 = {8'h00, 8'h00, 8'hFE, 8'h05};
        tbl[0].e2 = {8'h00, 8'h80, 8'hFF, 8'h01};
        tbl[1].e0 = {8'h00, 8'hFC, 8'hFE, 8'h05};
        tbl[1].e2 = {8'h80, 8'h7F, 8'hFF, 8'h01};
        tbl[2].e0 = {8'h7F, 8'h80, 8'h80, 8'h7F};
        tbl[2].e2 = {8'hDF, 8'hE0, 8'h20, 8'h1F};
        tbl[3].e0 = {8'hCB, 8'h34, 8'hFF, 8'h00};
        tbl[3].e2 = {8'h72, 8'h8D, 8'hFF, 8'h00};
`endif

        // ---------------- reset state ----------------
        rstn          = 1'b0;
        s_valid       = 1'b0;
        s_data        = '0;
        m_axis_tready = 1'b0;
        step();
        s_valid = 1'b1;          // offered during reset, must be ignored
        s_data  = tbl[0].col;
        step();
        check("reset s_ready", 32'(s_ready0), 32'd0);
        check("reset tvalid", 32'(tvalid0), 32'd0);
        check("reset tdata", 32'(tdata0), 32'd0);
        check("reset tlast", 32'(tlast0), 32'd0);
        check("reset busy", 32'(busy0), 32'd0);
        s_valid = 1'b0;
        rstn    = 1'b1;
        #1;
        check("s_ready after reset", 32'(s_ready0), 32'd1);
        step();
        check("idle busy", 32'(busy0), 32'd0);

        // ---------------- latency: beat 0 one cycle after accept ----------------
        m_axis_tready = 1'b1;
        send(0);
        check("lat tvalid at accept", 32'(tvalid0), 32'd0);
        check("lat busy at accept", 32'(busy0), 32'd1);
        step();
        check("lat tvalid beat0", 32'(tvalid0), 32'd1);
        check("lat tdata beat0", 32'(tdata0), 32'(tbl[0].e0[7:0]));
        for (int b = 1; b < R; b++) begin
            step();
            check($sformatf("lat beat%0d tdata", b), 32'(tdata0), 32'(tbl[0].e0[b*8 +: 8]));
            check($sformatf("lat beat%0d tlast", b), 32'(tlast0), 32'(b == R - 1));
        end
        step();
        check("lat tvalid after", 32'(tvalid0), 32'd0);

        // ---------------- table-driven narrowing ----------------
        for (int k = 0; k < 4; k++) begin
            offer_q = {k};
            exp_q   = {k};
            run_stream($sformatf("vec%0d", k), 40);
        end

        // ---------------- back-to-back, s_valid held ----------------
        offer_q = {1, 2, 3};
        exp_q   = {1, 2, 3};
        run_stream("b2b", 100);

        // ---------------- backpressure ----------------
        m_axis_tready = 1'b0;
        send(0);
        step();
        check("bp beat0 valid", 32'(tvalid0), 32'd1);
        s_valid = 1'b1;
        s_data  = tbl[1].col;
        check("bp second s_ready", 32'(s_ready0), 32'd1);
        step();
        s_data = tbl[2].col;     // third column stays offered
        for (int i = 0; i < 9; i++) begin
            check($sformatf("bp stall%0d s_ready", i), 32'(s_ready0), 32'd0);
            check($sformatf("bp stall%0d tvalid", i), 32'(tvalid0), 32'd1);
            check($sformatf("bp stall%0d tdata s0", i), 32'(tdata0), 32'(tbl[0].e0[7:0]));
            check($sformatf("bp stall%0d tdata s2", i), 32'(tdata2), 32'(tbl[0].e2[7:0]));
            check($sformatf("bp stall%0d tlast", i), 32'(tlast0), 32'd0);
            step();
        end
        m_axis_tready = 1'b1;
        offer_q = {2};
        exp_q   = {0, 1, 2};
        run_stream("bp release", 100);

        // ---------------- reset mid-packet with pending full ----------------
        m_axis_tready = 1'b0;
        send(3);
        step();
        s_valid = 1'b1;
        s_data  = tbl[1].col;
        step();
        s_valid       = 1'b0;
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check("mid beat1 tdata", 32'(tdata0), 32'(tbl[3].e0[15:8]));
        check("mid pending s_ready", 32'(s_ready0), 32'd0);
        rstn = 1'b0;
        step();
        check("mid reset tvalid", 32'(tvalid0), 32'd0);
        check("mid reset busy", 32'(busy0), 32'd0);
        check("mid reset tlast", 32'(tlast0), 32'd0);
        check("mid reset s_ready", 32'(s_ready0), 32'd0);
        rstn = 1'b1;
        #1;
        check("mid s_ready after reset", 32'(s_ready0), 32'd1);
        m_axis_tready = 1'b1;
        offer_q = {2};
        exp_q   = {2};
        run_stream("post reset", 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_drain.md
# acc_drain

Output drain for the systolic array. Captures one column of R accumulator results, each WY bits, in a single parallel handshake, for example when the accumulators finish a tile. It then narrows each result to WO bits by arithmetic shift plus saturate or truncate. Results are emitted serially, one per beat, on an AXI-Stream master with TLAST on the last beat. A one-deep pending buffer lets the next column be accepted while the current one drains.

## Interface
- R, 8: results per column (beats per packet), R ≥ 2
- WY, 16: accumulator result width, signed
- WO, 8: output word width, signed, WO ≤ WY
- SHIFT, 0: arithmetic right shift applied before narrowing, 0 ≤ SHIFT < WY
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- s_valid  in  1  column valid
- s_ready  out  1  column accepted when s_valid && s_ready
- s_data  in  R*WY  result i at [i*WY +: WY]
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  WO  narrowed result
- m_axis_tlast  out  1  high on beat R-1 of each column
- busy  out  1  active or pending buffer occupied, or tvalid high

## Operation
- Storage:
  - active buffer (R×WY) with index idx, 0..R-1;
  - pending buffer (R×WY) with flag pend_full;
  - output register (tdata, tlast, tvalid).
- States:
  - IDLE: active buffer empty.
  - DRAIN: active buffer holds a column.
- s_ready = rstn && !pend_full. Acceptance depends only on pend_full, never combinationally on m_axis_tready.
- Accept in IDLE: column loads into active buffer, idx=0, go to DRAIN.
- Accept in DRAIN: column loads into pending buffer, pend_full=1.
- In DRAIN, the output register loads word idx whenever it is empty or being consumed (!tvalid || tready).
  - Each load increments idx.
  - Loading idx=R-1 sets tlast=1 and retires the active buffer.
- Retire, three cases:
  - pend_full: pending moves to active, pend_full=0, idx=0, stay in DRAIN.
  - Else, if s_valid accepted in the same cycle: the new column goes straight to active, stay in DRAIN.
  - Else: go to IDLE.
- tvalid/tdata/tlast hold stable while tvalid && !tready (AXIS rule).
- tvalid clears when consumed and no new word loads.
- Narrowing, per word v:
  - t = v >>> SHIFT (sign-preserving floor).
  - Saturate or truncate t to WO bits (see Configuration).
- Boundaries:
  - Pending full and active retiring in the same cycle: s_ready stays 0 that cycle. It rises the next cycle.
  - tready held low indefinitely: both buffers fill, s_ready=0, no data lost or reordered.
  - Reset mid-packet: both buffers discarded, output register cleared. No partial packet resumes.

## Timing
- Reset values, at the first edge with rstn=0:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, busy=0.
  - State IDLE, idx=0, pend_full=0.
  - s_ready=0 while rstn=0.
- Latency: column accepted at edge t gives beat 0 valid after edge t+1.
- Throughput: one beat per cycle with tready=1.
- Back-to-back columns: beat 0 of column n+1 follows tlast of column n with zero bubbles when pending was full.
- With tready held 1 and s_valid held 1, the packet stream is continuous, R beats per column.

## Configuration
- ACC_DRAIN_SAT_EN defined:
  - t > 2^(WO-1)-1 gives 2^(WO-1)-1.
  - t < -2^(WO-1) gives -2^(WO-1).
  - Otherwise t[WO-1:0].
- ACC_DRAIN_SAT_EN undefined: tdata = t[WO-1:0] (wrap). The saturation comparators are not built.

## Test plan
All scenarios use R=4, WY=16, WO=8.
- SHIFT=0, SAT_EN defined:
  - Stimulus: column {0x0005, 0xFFFE, 0x0200, 0x8000}, tready=1.
  - Response: tdata 0x05, 0xFE, 0x7F, 0x80; tlast only on beat 3; beat 0 one cycle after accept.
- Same column, SAT_EN undefined:
  - Response: 0x05, 0xFE, 0x00, 0x00.
- SHIFT=2, SAT_EN defined:
  - Stimulus: column {0x0005, 0xFFFE, 0x01FC, 0xFE00}.
  - Response: 0x01, 0xFF, 0x7F, 0x80.
- Backpressure:
  - Stimulus: tready=0 for 10 cycles after beat 0 goes valid; three columns offered.
  - Response: tdata/tlast stable throughout; second column accepted; s_ready=0 for the third.
  - Release tready: 8 beats, in order, with no gaps; then the third column is accepted.
- Back-to-back:
  - Stimulus: s_valid held 1 with 3 distinct columns, tready=1.
  - Response: 12 consecutive valid beats; tlast on beats 3, 7, 11; busy falls 1 cycle after the final beat is consumed.
- Reset mid-packet:
  - Stimulus: rstn=0 for 1 cycle after beat 1 of a column, with pending full.
  - Response: tvalid=0 and busy=0 after that edge; the next accepted column starts at beat 0 with fresh data.
